dmux_reg_nway: RTL
==================

Name: dmux_reg_nway

Overview:
- Registered, parametrised 1-to-N demultiplexer with valid/ready handshake on the input and on every output channel.
- Each output channel has a one-entry holding register, so a stalled consumer blocks only its own channel.
- Successor to the combinational 8-way demux. Used wherever one producer stream is routed to several consumers with back-pressure.

Parameters:
- LARGURA, 4, data width in bits (>=1)
- N_SAIDAS, 8, number of output channels (2..64; need not be a power of 2)
- SEL_W, $clog2(N_SAIDAS), select width. Derived; not overridden.
- CONT_W, 8, width of each per-channel counter (used only with DMUX_CONTADORES_EN)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- entrada  in  LARGURA  input data word
- sel  in  SEL_W  destination channel index
- in_valid  in  1  producer offers entrada/sel this cycle
- in_ready  out  1  block accepts the offered word this cycle
- saida  out  N_SAIDAS*LARGURA  flattened channel data; channel k = bits [k*LARGURA +: LARGURA]
- out_valid  out  N_SAIDAS  channel k holds a valid word
- out_ready  in  N_SAIDAS  consumer k takes the word this cycle
- erro  out  1  one-cycle pulse: a word with sel >= N_SAIDAS was consumed and dropped
- contador  out  N_SAIDAS*CONT_W  per-channel accepted-word counts. Present only with DMUX_CONTADORES_EN.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, saida=0, erro=0, contador=0. Release is synchronous to clk.
- Reset mid-operation: all held words are discarded; no partial state survives.
- Transfer rules:
  - Input transfer when in_valid & in_ready at a rising edge.
  - Output transfer on channel k when out_valid[k] & out_ready[k].
- in_ready is combinational:
  - sel < N_SAIDAS: in_ready = !out_valid[sel] | out_ready[sel].
  - sel >= N_SAIDAS: in_ready = 1.
  - in_ready does not depend on in_valid.
  - A combinational path from out_ready to in_ready is intentional.
- Accepted word with sel = k < N_SAIDAS:
  - Channel k loads entrada; out_valid[k]=1 from the next cycle (latency 1).
  - Other channels are unaffected.
- Accepted word with sel >= N_SAIDAS: word dropped, no channel changes, erro=1 for exactly the next cycle.
- Channel k drained with no new load to k: out_valid[k] clears next cycle.
- Drain and load of channel k in the same edge: out_valid[k] stays 1 and data is replaced by the new word. This gives full throughput of 1 word/cycle per channel.
- While out_valid[k] & !out_ready[k]: saida channel k is held stable.
- Invalid channel (out_valid[k]=0): saida keeps the last loaded value (0 after reset). Consumers ignore it.
- Independent channels drain in parallel in the same cycle. At most one load per cycle, since there is a single input.
- in_valid=0: no state change except drains.
- No internal state machine beyond the per-channel valid bit.

Optional Feature:
- Macro: DMUX_CONTADORES_EN
- Defined:
  - Each channel keeps a CONT_W-bit counter of accepted words, incremented on the edge where that channel loads.
  - Counters wrap modulo 2^CONT_W and are reset only by rst_n.
  - Dropped (invalid sel) words are not counted.
  - Port contador is present.
- Undefined: no counters and no contador port; all other behaviour is identical.

Decomposition:
- Package dmux_pkg:
  - default constants LARGURA_PAD=4, N_SAIDAS_PAD=8, CONT_W_PAD=8
  - helper function for SEL_W
- Sub-module dmux_canal: one channel, generated N_SAIDAS times.
  - Inputs: carga, entrada, out_ready.
  - Outputs: dado, valido, ocupado_bloqueia (= valido & !out_ready).
  - Holds the optional counter under the same macro.
- Top level: in_ready mux, sel range check, erro register, output flattening.

Test Plan (LARGURA=4, N_SAIDAS=8 unless stated):
- Sweep: all out_ready=1; offer entrada=4'h1 with sel=0..7, one per cycle. Each out_valid[k] pulses for one cycle, one cycle after its load, with saida channel k=1. Other channels are not asserted.
- Back-pressure: out_ready[3]=0. Send 4'hA to sel 3, then 4'hB to sel 3.
  - First word accepted; in_ready=0 for the second; channel 3 holds 4'hA stable.
  - Raise out_ready[3]: in_ready=1 the same cycle; next cycle channel 3 shows 4'hB, out_valid[3] still 1.
- Isolation: channel 2 stalled and full; send 4'h5 to sel 6. Accepted immediately, channel 6 valid next cycle, channel 2 unchanged.
- Out-of-range (N_SAIDAS=6): send 4'hF with sel=7. in_ready=1, word dropped, erro=1 for exactly one cycle, all out_valid=0.
- Reset mid-operation: channels 1 and 4 full and stalled; pulse rst_n=0 between clock edges. out_valid=0 and saida=0 immediately, without waiting for clk.
- With DMUX_CONTADORES_EN, CONT_W=4:
  - 17 words to sel 5: contador channel 5 = 1 (wrap).
  - Dropped words leave all counters unchanged.

Source files
------------

// File: rtl/dmux_pkg.sv
// dmux_pkg: default sizes and select-width helper shared by the registered demux slice.
package dmux_pkg;
    localparam int LARGURA_PAD  = 4;
    localparam int N_SAIDAS_PAD = 8;
    localparam int CONT_W_PAD   = 8;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/dmux_reg_nway_if.sv
// dmux_reg_nway_if: producer-side handshake plus per-channel consumer buses of the demux.
interface dmux_reg_nway_if
    import dmux_pkg::*;
#(
    parameter int LARGURA  = LARGURA_PAD,
    parameter int N_SAIDAS = N_SAIDAS_PAD
);
    localparam int SEL_W = sel_w(N_SAIDAS);

    logic [LARGURA-1:0]          entrada;
    logic [SEL_W-1:0]            sel;
    logic                        in_valid;
    logic                        in_ready;
    logic [N_SAIDAS*LARGURA-1:0] saida;
    logic [N_SAIDAS-1:0]         out_valid;
    logic [N_SAIDAS-1:0]         out_ready;
    logic                        erro;

    modport master (
        output entrada, sel, in_valid, out_ready,
        input  in_ready, saida, out_valid, erro
    );

    modport slave (
        input  entrada, sel, in_valid, out_ready,
        output in_ready, saida, out_valid, erro
    );
endinterface

// File: rtl/dmux_canal.sv
// dmux_canal: one output channel with a single-entry holding register.
// Optional accepted-word counter under DMUX_CONTADORES_EN.
module dmux_canal #(
    parameter int LARGURA = 4
`ifdef DMUX_CONTADORES_EN
    , parameter int CONT_W = 8
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               carga,
    input  logic [LARGURA-1:0] entrada,
    input  logic               out_ready,
    output logic [LARGURA-1:0] dado,
    output logic               valido,
    output logic               ocupado_bloqueia
`ifdef DMUX_CONTADORES_EN
    , output logic [CONT_W-1:0] contador
`endif
);
    logic               valido_d, valido_q;
    logic [LARGURA-1:0] dado_d, dado_q;
`ifdef DMUX_CONTADORES_EN
    logic [CONT_W-1:0]  cont_d, cont_q;
`endif

    // a load on the draining edge keeps the channel valid, giving 1 word/cycle
    always_comb begin
        valido_d = carga | (valido_q & !out_ready);
        dado_d   = carga ? entrada : dado_q;
`ifdef DMUX_CONTADORES_EN
        cont_d   = cont_q + CONT_W'(carga);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valido_q <= 1'b0;
            dado_q   <= '0;
`ifdef DMUX_CONTADORES_EN
            cont_q   <= '0;
`endif
        end else begin
            valido_q <= valido_d;
            dado_q   <= dado_d;
`ifdef DMUX_CONTADORES_EN
            cont_q   <= cont_d;
`endif
        end
    end

    assign dado             = dado_q;
    assign valido           = valido_q;
    assign ocupado_bloqueia = valido_q & !out_ready;
`ifdef DMUX_CONTADORES_EN
    assign contador         = cont_q;
`endif
endmodule

// File: rtl/dmux_reg_nway.sv
// dmux_reg_nway: registered 1-to-N demux with valid/ready on input and every channel.
// Optional per-channel word counters (port contador) under DMUX_CONTADORES_EN.
module dmux_reg_nway
    import dmux_pkg::*;
#(
    parameter int LARGURA  = LARGURA_PAD,
    parameter int N_SAIDAS = N_SAIDAS_PAD
`ifdef DMUX_CONTADORES_EN
    , parameter int CONT_W = CONT_W_PAD
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmux_reg_nway_if.slave       bus
`ifdef DMUX_CONTADORES_EN
    , output logic [N_SAIDAS*CONT_W-1:0] contador
`endif
);
    localparam int SEL_W = sel_w(N_SAIDAS);

    logic [N_SAIDAS-1:0]   carga, bloqueia;
    logic [2**SEL_W-1:0]   bloq_ext;
    logic                  sel_ok, aceita, erro_d, erro_q;

    // unused select codes read as never-blocked, so out-of-range words are always taken
    always_comb begin
        bloq_ext                 = '0;
        bloq_ext[N_SAIDAS-1:0]   = bloqueia;
        sel_ok                   = 32'(bus.sel) < 32'(N_SAIDAS);
        bus.in_ready             = !bloq_ext[bus.sel];
        aceita                   = bus.in_valid & bus.in_ready;
        erro_d                   = aceita & !sel_ok;
    end

    for (genvar k = 0; k < N_SAIDAS; k++) begin : g_canal
        assign carga[k] = aceita & (bus.sel == SEL_W'(k));
        dmux_canal #(
            .LARGURA(LARGURA)
`ifdef DMUX_CONTADORES_EN
            , .CONT_W(CONT_W)
`endif
        ) u_canal (
            .clk              (clk),
            .rst_n            (rst_n),
            .carga            (carga[k]),
            .entrada          (bus.entrada),
            .out_ready        (bus.out_ready[k]),
            .dado             (bus.saida[k*LARGURA +: LARGURA]),
            .valido           (bus.out_valid[k]),
            .ocupado_bloqueia (bloqueia[k])
`ifdef DMUX_CONTADORES_EN
            , .contador       (contador[k*CONT_W +: CONT_W])
`endif
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) erro_q <= 1'b0;
        else        erro_q <= erro_d;
    end

    assign bus.erro = erro_q;
endmodule
